// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register for the RV32I pipeline.
// PCF drives the instruction memory; the returned word is captured into the
// decode-side register along with its PC, PC+4 and a valid bit.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             PCSrcE,
    input  logic [31:0]      PCTargetE,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic             fetch_stall,
    output logic [31:0]      PCF,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCD,
    output logic [31:0]      PCPlus4D,
    output logic             ValidD,
    output logic [CNT_W-1:0] fetch_count
);

    logic [31:0]      pcf_q,    pcf_d;
    logic [31:0]      instr_q,  instr_d;
    logic [31:0]      pcd_q,    pcd_d;
    logic [31:0]      pcp4_q,   pcp4_d;
    logic             valid_q,  valid_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [31:0]      pcf_plus4;
    logic [31:0]      target_aligned;

    // Misaligned redirect targets are silently word-aligned.
    assign target_aligned = PCTargetE & ~32'h0000_0003;
    assign pcf_plus4      = pcf_q + 32'd4;

    assign imem_req    = rst_n;
    assign imem_addr   = pcf_q;
    assign fetch_stall = imem_req & ~imem_ready;

    // Next PC: redirect beats any hold; a stalled or not-ready fetch holds.
    always_comb begin
        pcf_d = pcf_plus4;
        if (PCSrcE)
            pcf_d = target_aligned;
        else if (StallF || !imem_ready)
            pcf_d = pcf_q;
    end

    // Next IF/ID contents: flush > hold > load > bubble.
    always_comb begin
        instr_d = NOP_INSTR;
        pcd_d   = 32'd0;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        if (FlushD) begin
            instr_d = NOP_INSTR;
        end else if (StallD) begin
            instr_d = instr_q;
            pcd_d   = pcd_q;
            pcp4_d  = pcp4_q;
            valid_d = valid_q;
        end else if (imem_ready) begin
            instr_d = imem_rdata;
            pcd_d   = pcf_q;
            pcp4_d  = pcf_plus4;
            valid_d = 1'b1;
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with synchronous reset dropping all in-flight work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcf_q   <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'd0;
            pcp4_q  <= 32'd0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pcf_q   <= pcf_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PCF         = pcf_q;
    assign InstrD      = instr_q;
    assign PCD         = pcd_q;
    assign PCPlus4D    = pcp4_q;
    assign ValidD      = valid_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic,
// checked against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          CNT_W     = 16;

    logic             clk = 1'b0;
    logic             rst_n, StallF, StallD, FlushD, PCSrcE, imem_ready;
    logic [31:0]      PCTargetE, imem_rdata, imem_addr;
    logic             imem_req, fetch_stall, ValidD;
    logic [31:0]      PCF, InstrD, PCD, PCPlus4D;
    logic [CNT_W-1:0] fetch_count;

    int npass = 0;
    int ntot  = 0;

    // Reference model state
    logic [31:0]      m_pc, m_instr, m_pcd, m_p4;
    logic             m_valid;
    logic [CNT_W-1:0] m_cnt;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .fetch_stall(fetch_stall),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .fetch_count(fetch_count)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_comb imem_rdata = memw(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    endtask

    // One clock: drive inputs, check combinational outputs, advance model, check registers.
    task automatic cyc(input logic rst, input logic sf, input logic sd, input logic fd,
                       input logic pcs, input logic [31:0] tgt, input logic rdy);
        logic [31:0] word;
        rst_n = rst; StallF = sf; StallD = sd; FlushD = fd;
        PCSrcE = pcs; PCTargetE = tgt; imem_ready = rdy;
        #1;
        chk("imem_req",    {31'd0, imem_req},    {31'd0, rst});
        chk("imem_addr",   imem_addr,            m_pc);
        chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, rst & ~rdy});
        @(posedge clk);
        word = memw(m_pc);
        if (!rst) begin
            m_pc = RESET_PC; m_instr = NOP_INSTR; m_pcd = 0; m_p4 = 0; m_valid = 0; m_cnt = 0;
        end else begin
            if (fd || (!sd && !rdy)) begin
                m_instr = NOP_INSTR; m_pcd = 0; m_p4 = 0; m_valid = 0;
            end else if (!sd) begin
                m_instr = word; m_pcd = m_pc; m_p4 = m_pc + 32'd4; m_valid = 1; m_cnt = m_cnt + 1'b1;
            end
            if (pcs)             m_pc = {tgt[31:2], 2'b00};
            else if (!sf && rdy) m_pc = m_pc + 32'd4;
        end
        #1;
        chk("PCF",         PCF,                  m_pc);
        chk("InstrD",      InstrD,               m_instr);
        chk("PCD",         PCD,                  m_pcd);
        chk("PCPlus4D",    PCPlus4D,             m_p4);
        chk("ValidD",      {31'd0, ValidD},      {31'd0, m_valid});
        chk("fetch_count", {16'd0, fetch_count}, {16'd0, m_cnt});
    endtask

    initial begin
        m_pc = RESET_PC; m_instr = NOP_INSTR; m_pcd = 0; m_p4 = 0; m_valid = 0; m_cnt = 0;
        rst_n = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0; imem_ready = 1;
        @(negedge clk);

        // Reset then free run
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("rst_PCF",   PCF,                     RESET_PC);
        chk("rst_Instr", InstrD,                  NOP_INSTR);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        // Joint stall at PCF=8
        chk("pre_stall_PCF", PCF, 32'h8);
        cyc(1, 1, 1, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 0, 1);
        chk("stall_PCD", PCD, 32'h4);
        chk("stall_cnt", {16'd0, fetch_count}, 32'd2);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("resume_Instr", InstrD, memw(32'h8));
        chk("cnt3",         {16'd0, fetch_count}, 32'd3);
        // Redirect with flush to misaligned 0x102 at PCF=0x10
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 1, 32'h0000_0102, 1);
        chk("redir_PCF",   PCF,    32'h100);
        chk("redir_Instr", InstrD, NOP_INSTR);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("redir_next", InstrD, memw(32'h100));
        // Memory not ready for 3 cycles at PCF=0x20
        cyc(1, 0, 0, 1, 1, 32'h20, 1);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        chk("nr_PCF", PCF, 32'h20);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("nr_load", InstrD, memw(32'h20));
        // Wrap at top of address space
        cyc(1, 0, 0, 1, 1, 32'hFFFF_FFFC, 1);
        chk("wrap_PCF0", PCF, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("wrap_PCF1", PCF, 32'h0);
        chk("wrap_P4D",  PCPlus4D, 32'h0);
        // Reset mid-stream with StallD and PCSrcE high
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 1, 32'h4000, 1);
        chk("mrst_PCF", PCF, RESET_PC);
        chk("mrst_val", {31'd0, ValidD}, 32'd0);
        chk("mrst_cnt", {16'd0, fetch_count}, 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic r, sf, sd, fd, pcs, rdy;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 39) != 0);
            sf  = ($urandom_range(0, 5) == 0);
            sd  = ($urandom_range(0, 3) == 0) ? ~sf : sf;
            pcs = ($urandom_range(0, 9) == 0);
            fd  = pcs ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFF8 | $urandom_range(0, 7);
                default: tgt = $urandom;
            endcase
            cyc(r, sf, sd, fd, pcs, tgt, rdy);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
